sc_dmem_io: RTL



---
 rtl/sc_dmem_io.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sc_dmem_io.sv
// Data-side memory stage: word-addressed RAM plus an I/O window with LED, switches and a timer.
// Optional macro SC_DMEM_BYTE_WRITE_EN adds the wbe[3:0] byte-enable input.
module sc_dmem_io #(
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_FF00,
  parameter int          SW_WIDTH  = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [31:0]         addr,
  input  logic [31:0]         datain,
  input  logic                we,
`ifdef SC_DMEM_BYTE_WRITE_EN
  input  logic [3:0]          wbe,
`endif
  output logic [31:0]         dataout,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic [SW_WIDTH-1:0] led,
  output logic                timer_irq
);

  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [7:0] OFF_LED   = 8'h00;
  localparam logic [7:0] OFF_SW    = 8'h04;
  localparam logic [7:0] OFF_TCNT  = 8'h08;
  localparam logic [7:0] OFF_TCMP  = 8'h0C;
  localparam logic [7:0] OFF_TCTRL = 8'h10;
  localparam logic [7:0] OFF_TSTAT = 8'h14;

  logic [31:0]          r_ram [DEPTH];
  logic [SW_WIDTH-1:0]  r_led, r_sw_meta, r_sw_sync;
  logic [31:0]          r_tcnt, r_tcmp;
  logic                 r_en, r_auto, r_match;

  logic                 w_io_sel, w_wr_io, w_wr_ram, w_full, w_hit;
  logic [7:0]           w_off;
  logic [ADDR_BITS-1:0] w_idx;
  logic [3:0]           w_bmask;
  logic [SW_WIDTH-1:0]  w_led_mask, w_led_nx;
  logic [31:0]          w_tcnt_nx, w_rdata;
  logic                 w_en_nx, w_auto_nx, w_match_nx;

  assign w_io_sel = (addr[31:8] == IO_BASE[31:8]);
  assign w_off    = addr[7:0];
  assign w_idx    = addr[ADDR_BITS+1:2];
  assign w_wr_io  = we && w_io_sel;
  assign w_wr_ram = resetn && we && !w_io_sel;
`ifdef SC_DMEM_BYTE_WRITE_EN
  assign w_bmask  = wbe;
`else
  assign w_bmask  = 4'hF;
`endif
  // Timer/status registers only accept complete words.
  assign w_full   = (w_bmask == 4'hF);
  assign w_hit    = r_en && (r_tcnt == r_tcmp);

  // LED byte-lane mask derived from the byte enables.
  always_comb begin
    w_led_mask = '0;
    for (int i = 0; i < SW_WIDTH; i++) begin
`ifdef SC_DMEM_BYTE_WRITE_EN
      if (i < 8) begin
        w_led_mask[i] = w_bmask[0];
      end else if (i < 16) begin
        w_led_mask[i] = w_bmask[1];
      end else begin
        w_led_mask[i] = 1'b0;
      end
`else
      w_led_mask[i] = 1'b1;
`endif
    end
  end

  // Next-state for LED and timer; core writes are applied last so they win.
  always_comb begin
    w_led_nx   = r_led;
    w_tcnt_nx  = r_tcnt;
    w_en_nx    = r_en;
    w_auto_nx  = r_auto;
    w_match_nx = r_match;
    if (w_hit) begin
      w_match_nx = 1'b1;
      if (r_auto) begin
        w_tcnt_nx = 32'h0;
      end else begin
        w_en_nx = 1'b0;
      end
    end else if (r_en) begin
      w_tcnt_nx = r_tcnt + 32'd1;
    end else begin
      w_tcnt_nx = r_tcnt;
    end
    if (w_wr_io) begin
      case (w_off)
        OFF_LED:   w_led_nx = (r_led & ~w_led_mask) | (datain[SW_WIDTH-1:0] & w_led_mask);
        OFF_TCNT:  w_tcnt_nx = w_full ? datain : w_tcnt_nx;
        OFF_TCMP:  w_led_nx = r_led;
        OFF_TCTRL: begin
          w_en_nx   = w_full ? datain[0] : w_en_nx;
          w_auto_nx = w_full ? datain[1] : r_auto;
        end
        // A match in this same cycle keeps MATCH set.
        OFF_TSTAT: w_match_nx = (w_full && datain[0] && !w_hit) ? 1'b0 : w_match_nx;
        default:   w_led_nx = r_led;
      endcase
    end else begin
      w_led_nx = r_led;
    end
  end

  // Peripheral registers and switch synchroniser with synchronous reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_tcnt    <= 32'h0;
      r_tcmp    <= 32'hFFFF_FFFF;
      r_en      <= 1'b0;
      r_auto    <= 1'b0;
      r_match   <= 1'b0;
    end else begin
      r_led     <= w_led_nx;
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
      r_tcnt    <= w_tcnt_nx;
      r_tcmp    <= (w_wr_io && w_full && (w_off == OFF_TCMP)) ? datain : r_tcmp;
      r_en      <= w_en_nx;
      r_auto    <= w_auto_nx;
      r_match   <= w_match_nx;
    end
  end

  // RAM write port; contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (w_wr_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (w_bmask[b]) begin
          r_ram[w_idx][8*b +: 8] <= datain[8*b +: 8];
        end
      end
    end
  end

  // Combinational load path.
  always_comb begin
    w_rdata = 32'h0;
    if (w_io_sel) begin
      case (w_off)
        OFF_LED:   w_rdata = 32'(r_led);
        OFF_SW:    w_rdata = 32'(r_sw_sync);
        OFF_TCNT:  w_rdata = r_tcnt;
        OFF_TCMP:  w_rdata = r_tcmp;
        OFF_TCTRL: w_rdata = {30'h0, r_auto, r_en};
        OFF_TSTAT: w_rdata = {31'h0, r_match};
        default:   w_rdata = 32'h0;
      endcase
    end else begin
      w_rdata = r_ram[w_idx];
    end
  end

  assign dataout   = w_rdata;
  assign led       = r_led;
  assign timer_irq = r_match;

endmodule
